// File: rtl/ai_cache_arbiter.sv
// Round-robin arbiter sharing one direct-mapped cache among NUM_REQ requesters.
// Sequences registered cache lookups, refills misses from backing memory, writes through.
module ai_cache_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    output logic [ID_W-1:0]               rsp_id,
    output logic                          rsp_hit,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          cache_read_en,
    output logic                          cache_write_en,
    output logic [ADDR_WIDTH-1:0]         cache_addr,
    output logic [DATA_WIDTH-1:0]         cache_write_data,
    input  logic [DATA_WIDTH-1:0]         cache_read_data,
    input  logic                          cache_hit,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic                          mem_req_write,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic                          mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]         mem_rsp_data,
    output logic                          busy
);

    typedef enum logic [3:0] {
        IDLE, LOOKUP, CHECK, MISS_REQ, MISS_WAIT, FILL, WR_CACHE, MEM_WR, RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         last_grant_q, last_grant_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    hit_q, hit_d;

    logic                    grant_found;
    logic [ID_W-1:0]         grant_idx;
    logic [ID_W:0]           cand;

    // Search starts one past the last winner; the extra bit absorbs the wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = {1'b0, last_grant_q} + (ID_W+1)'(off);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (reset && !grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        id_d             = id_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        data_d           = data_q;
        hit_d            = hit_q;
        req_ready        = '0;
        rsp_valid        = 1'b0;
        rsp_id           = '0;
        rsp_hit          = 1'b0;
        rsp_data         = '0;
        cache_read_en    = 1'b0;
        cache_write_en   = 1'b0;
        cache_addr       = '0;
        cache_write_data = '0;
        mem_req_valid    = 1'b0;
        mem_req_write    = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;

        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready    = NUM_REQ'(1) << grant_idx;
                    last_grant_d = grant_idx;
                    id_d         = grant_idx;
                    addr_d       = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d      = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                    data_d       = '0;
                    hit_d        = 1'b0;
                    state_d      = req_write[grant_idx] ? WR_CACHE : LOOKUP;
                end
            end
            LOOKUP: begin
                cache_read_en = 1'b1;
                cache_addr    = addr_q;
                state_d       = CHECK;
            end
            CHECK: begin
                if (cache_hit) begin
                    data_d  = cache_read_data;
                    hit_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = addr_q;
                if (mem_req_ready) state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (mem_rsp_valid) begin
                    data_d  = mem_rsp_data;
                    state_d = FILL;
                end
            end
            FILL: begin
                cache_write_en   = 1'b1;
                cache_addr       = addr_q;
                cache_write_data = data_q;
                state_d          = RESP;
            end
            WR_CACHE: begin
                cache_write_en   = 1'b1;
                cache_addr       = addr_q;
                cache_write_data = wdata_q;
                state_d          = MEM_WR;
            end
            MEM_WR: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_addr      = addr_q;
                mem_wdata     = wdata_q;
                if (mem_req_ready) state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = id_q;
                rsp_hit   = hit_q;
                rsp_data  = data_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            data_q       <= '0;
            hit_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            data_q       <= data_d;
            hit_q        <= hit_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ai_cache_arbiter.sv
// Directed bench for ai_cache_arbiter with cache/memory models and a response scoreboard.
module tb_ai_cache_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 128;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_write = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_wdata = '0;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic              rsp_hit;
    logic [DW-1:0]     rsp_data;
    logic              cache_read_en, cache_write_en;
    logic [AW-1:0]     cache_addr;
    logic [DW-1:0]     cache_write_data;
    logic [DW-1:0]     cache_read_data = '0;
    logic              cache_hit = 1'b0;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic              mem_req_write;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_rsp_valid;
    logic [DW-1:0]     mem_rsp_data;
    logic              busy;

    localparam logic [DW-1:0] DA5   = {16{8'hA5}};
    localparam logic [DW-1:0] D5A   = {16{8'h5A}};
    localparam logic [DW-1:0] STRAY = 128'hDEAD_BEEF;

    ai_cache_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_hit(rsp_hit), .rsp_data(rsp_data),
        .cache_read_en(cache_read_en), .cache_write_en(cache_write_en), .cache_addr(cache_addr),
        .cache_write_data(cache_write_data), .cache_read_data(cache_read_data), .cache_hit(cache_hit),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cache model: registered read data/hit one cycle after read_en.
    logic [DW-1:0] cmem [logic [AW-1:0]];
    always @(posedge clk) begin
        if (cache_read_en) begin
            cache_hit       <= cmem.exists(cache_addr);
            cache_read_data <= cmem.exists(cache_addr) ? cmem[cache_addr] : '0;
        end else begin
            cache_hit       <= 1'b0;
            cache_read_data <= '0;
        end
        if (cache_write_en) cmem[cache_addr] = cache_write_data;
    end

    // Backing memory: read response appears mem_lat cycles after the accept cycle.
    logic [DW-1:0] bmem [logic [AW-1:0]];
    logic          mdl_valid = 1'b0;
    logic [DW-1:0] mdl_data = '0;
    logic [DW-1:0] pend_data = '0;
    int            pend = 0;
    int            mem_lat = 1;
    logic          stray = 1'b0;
    assign mem_rsp_valid = mdl_valid | stray;
    assign mem_rsp_data  = stray ? STRAY : mdl_data;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdl_valid <= 1'b0;
            pend      <= 0;
        end else begin
            mdl_valid <= 1'b0;
            if (pend > 0) begin
                pend <= pend - 1;
                if (pend == 1) begin
                    mdl_valid <= 1'b1;
                    mdl_data  <= pend_data;
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                if (mem_req_write) begin
                    bmem[mem_addr] = mem_wdata;
                end else if (mem_lat <= 1) begin
                    mdl_valid <= 1'b1;
                    mdl_data  <= bmem.exists(mem_addr) ? bmem[mem_addr] : '0;
                end else begin
                    pend      <= mem_lat - 1;
                    pend_data <= bmem.exists(mem_addr) ? bmem[mem_addr] : '0;
                end
            end
        end
    end

    // Scoreboard
    typedef struct {
        int            id;
        logic          hit;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t exp_q[$];

    always @(negedge clk) begin
        if (reset) begin
            if (busy) chk("ready_while_busy", DW'(req_ready), '0);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", DW'(rsp_valid), '0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_id", DW'(rsp_id), DW'(e.id));
                    chk("rsp_hit", DW'(rsp_hit), DW'(e.hit));
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_cycle", DW'(cyc), DW'(e.cyc));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        for (int i = 0; i < 200 && cyc < c; i++) step();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ctl"}, DW'({req_ready, rsp_valid, rsp_id, rsp_hit, cache_read_en, cache_write_en,
                                mem_req_valid, mem_req_write, busy}), '0);
        chk({tag, "_rsp_data"}, rsp_data, '0);
        chk({tag, "_addrs"}, DW'({cache_addr, mem_addr}), '0);
        chk({tag, "_cwdata"}, cache_write_data, '0);
        chk({tag, "_mwdata"}, mem_wdata, '0);
    endtask

    // Raise one request, wait (bounded) for its grant, push the expected response.
    task automatic issue(input int id, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic ehit, input logic [DW-1:0] edata, input int lat, output int g);
        logic          got;
        logic [NR-1:0] oh;
        got = 1'b0;
        g   = -1;
        oh  = '0;
        oh[id] = 1'b1;
        req_write[id]          = wr;
        req_addr[id*AW +: AW]  = a;
        req_wdata[id*DW +: DW] = d;
        req_valid[id]          = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                got = 1'b1;
                g   = cyc;
                chk("grant_onehot", DW'(req_ready), DW'(oh));
                if (lat >= 0) exp_q.push_back('{id, ehit, edata, cyc + lat});
            end
            step();
        end
        req_valid[id] = 1'b0;
        chk("grant_seen", DW'(got), DW'(1));
    endtask

    // Collect grants from several requesters held high together.
    task automatic collect(input int n_exp, input int ord[5], input logic [DW-1:0] dat[5],
                           input int keep0, input int stray_cycles);
        int n, prev, k;
        n = 0;
        prev = 0;
        for (int i = 0; i < 80 && n < n_exp; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                k = -1;
                for (int b = 0; b < NR; b++) if (req_ready[b]) k = b;
                chk("grant_order", DW'(k), DW'(ord[n]));
                if (n > 0) chk("grant_spacing", DW'(cyc - prev), DW'(4));
                prev = cyc;
                exp_q.push_back('{ord[n], 1'b1, dat[n], cyc + 3});
                n++;
                step();
                if (!(k == 0 && keep0 != 0 && n == 1) && k >= 0) req_valid[k] = 1'b0;
                if (n == n_exp) req_valid = '0;
            end else begin
                step();
            end
            if (i + 1 >= stray_cycles) stray = 1'b0;
        end
        req_valid = '0;
        stray     = 1'b0;
        chk("grant_count", DW'(n), DW'(n_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int ord[5];
        logic [DW-1:0] dat[5];

        bmem[32'h80]  = 128'h1234;
        bmem[32'h200] = 128'h777;

        // Reset: outputs stay zero even with a request pending.
        reset = 1'b0;
        req_valid[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outputs_zero("rst");
            step();
        end
        req_valid = '0;
        reset = 1'b1;
        @(negedge clk);
        check_outputs_zero("post_rst");
        step();

        // Write then read hit.
        mem_req_ready = 1'b1;
        mem_lat = 1;
        issue(1, 1'b1, 32'h40, DA5, 1'b0, '0, 3, g);
        @(negedge clk);
        chk("wr_c1_strobes", DW'({cache_write_en, cache_read_en, mem_req_valid}), DW'(3'b100));
        chk("wr_c1_addr", DW'(cache_addr), DW'(32'h40));
        chk("wr_c1_data", cache_write_data, DA5);
        step();
        @(negedge clk);
        chk("wr_c2_mem", DW'({mem_req_valid, mem_req_write, cache_write_en}), DW'(3'b110));
        chk("wr_c2_addr", DW'(mem_addr), DW'(32'h40));
        chk("wr_c2_wdata", mem_wdata, DA5);
        step();

        issue(1, 1'b0, 32'h40, '0, 1'b1, DA5, 3, g);
        @(negedge clk);
        chk("rd_c1_read_en", DW'({cache_read_en, cache_write_en}), DW'(2'b10));
        chk("rd_c1_addr", DW'(cache_addr), DW'(32'h40));
        wait_until(g + 4);

        // Read miss: memory accepts after 2 wait cycles, responds 4 cycles later.
        mem_req_ready = 1'b0;
        mem_lat = 4;
        issue(2, 1'b0, 32'h80, '0, 1'b0, 128'h1234, 11, g);
        wait_until(g + 3);
        @(negedge clk);
        chk("miss_req", DW'({mem_req_valid, mem_req_write}), DW'(2'b10));
        chk("miss_addr", DW'(mem_addr), DW'(32'h80));
        wait_until(g + 5);
        mem_req_ready = 1'b1;
        wait_until(g + 10);
        @(negedge clk);
        chk("fill_strobe", DW'({cache_write_en, cache_read_en}), DW'(2'b10));
        chk("fill_addr", DW'(cache_addr), DW'(32'h80));
        chk("fill_data", cache_write_data, 128'h1234);
        wait_until(g + 12);
        mem_lat = 1;
        issue(2, 1'b0, 32'h80, '0, 1'b1, 128'h1234, 3, g);
        wait_until(g + 4);

        // Round-robin with every requester held from reset.
        reset = 1'b0;
        req_write = '0;
        for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = (i % 2 == 0) ? 32'h40 : 32'h80;
        req_valid = '1;
        step();
        step();
        reset = 1'b1;
        ord = '{0, 1, 2, 3, 0};
        dat = '{DA5, 128'h1234, DA5, 128'h1234, DA5};
        collect(5, ord, dat, 1, 0);
        wait_until(cyc + 5);

        // Reset in MISS_WAIT discards the transaction.
        mem_lat = 20;
        issue(3, 1'b0, 32'h200, '0, 1'b0, '0, -1, g);
        wait_until(g + 5);
        @(negedge clk);
        chk("midrst_busy_before", DW'(busy), DW'(1));
        #2;
        reset = 1'b0;
        #1;
        check_outputs_zero("midrst");
        step();
        req_addr[0*AW +: AW] = 32'h40;
        req_addr[2*AW +: AW] = 32'h80;
        req_valid[0] = 1'b1;
        req_valid[2] = 1'b1;
        step();
        reset = 1'b1;
        stray = 1'b1;
        ord = '{0, 2, 0, 0, 0};
        dat = '{DA5, 128'h1234, '0, '0, '0};
        collect(2, ord, dat, 0, 3);
        wait_until(cyc + 5);

        // Write-through with 10 cycles of memory backpressure.
        mem_req_ready = 1'b0;
        mem_lat = 1;
        issue(0, 1'b1, 32'h100, D5A, 1'b0, '0, 13, g);
        for (int i = 0; i < 10; i++) begin
            wait_until(g + 2 + i);
            @(negedge clk);
            chk("bp_ctl", DW'({mem_req_valid, mem_req_write, rsp_valid}), DW'(3'b110));
            chk("bp_addr", DW'(mem_addr), DW'(32'h100));
            chk("bp_wdata", mem_wdata, D5A);
        end
        wait_until(g + 12);
        mem_req_ready = 1'b1;
        wait_until(g + 14);
        chk("bp_mem_written", bmem.exists(32'h100) ? bmem[32'h100] : '0, D5A);
        issue(3, 1'b0, 32'h100, '0, 1'b1, D5A, 3, g);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
        chk("scoreboard_drained", DW'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
